camera_capture: RTL and testbench

//  Downstream consumer of the camera byte stream. On a start pulse it holds cam_en for exactly one

---
 rtl/camera_capture_pkg.sv | 24 ++
 rtl/camera_capture_fifo.sv | 60 ++++++
 rtl/camera_capture.sv | 159 +++++++++++++++
 tb/tb_camera_capture.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_capture_pkg.sv
// rtl/camera_capture_pkg.sv - shared states, frame geometry and FIFO word layout for camera_capture
package camera_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      TAIL    = 2'd2,
      DRAIN   = 2'd3
   } state_e;

   localparam int DEF_IMG_W = 15;
   localparam int DEF_IMG_H = 5;
   localparam int TOTAL     = DEF_IMG_W * DEF_IMG_H;

   // Tag bit offsets above the data field: FIFO word = {sof, eol, eof, data}
   localparam int TAG_SOF = 2;
   localparam int TAG_EOL = 1;
   localparam int TAG_EOF = 0;

   function automatic int frame_pixels(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/camera_capture_fifo.sv
// rtl/camera_capture_fifo.sv - synchronous first-word-fall-through FIFO
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (flushes contents)
//   wr_en, wr_data   push request; taken when not full, or when full and popping
//   full             occupancy == DEPTH
//   rd_en            pop request; taken when not empty
//   rd_data          head entry (valid only while !empty)
//   empty            occupancy == 0
module capture_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign rd_data = mem_q[rd_ptr_q];
   assign do_rd   = rd_en && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign do_wr   = wr_en && (!full || do_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - one-frame camera capture with positional tagging into a FWFT FIFO
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle frame request, honoured only in IDLE
//   cam_en                   camera enable, high for exactly IMG_W*IMG_H cycles
//   cam_valid, cam_data      camera byte stream (one cycle behind cam_en)
//   pix_valid/ready/data     tagged pixel stream out of the FIFO head
//   pix_sof/eol/eof          position tags of the head pixel
//   busy                     frame in progress
//   overflow                 sticky: a byte was dropped on a full FIFO
//   frame_done               one-cycle pulse when the frame has fully drained
module camera_capture
   import camera_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int IMG_W      = 15,
   parameter int IMG_H      = 5,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              cam_en,
   input  logic              cam_valid,
   input  logic [DATA_W-1:0] cam_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic              busy,
   output logic              overflow,
   output logic              frame_done
);

   localparam int FTOTAL = frame_pixels(IMG_W, IMG_H);
   localparam int RCW    = $clog2(FTOTAL);
   localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int HW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int EW     = DATA_W + 3;

   state_e          state_q;
   logic [RCW-1:0]  req_cnt_q;
   logic [CW-1:0]   col_q;
   logic [HW-1:0]   row_q;
   logic            cam_en_q;
   logic            busy_q;
   logic            overflow_q;
   logic            frame_done_q;

   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            last_col;
   logic            last_row;
   logic [EW-1:0]   wr_word;
   logic [EW-1:0]   rd_word;

   // Stray bytes after a reset land in IDLE and must not be stored
   assign push = cam_valid && (state_q != IDLE);
   assign pop  = pix_ready && !fifo_empty;

   always_comb begin
      last_col = (col_q == CW'(IMG_W - 1));
      last_row = (row_q == HW'(IMG_H - 1));
      wr_word  = '0;
      wr_word[DATA_W-1:0]       = cam_data;
      wr_word[DATA_W + TAG_SOF] = (col_q == '0) && (row_q == '0);
      wr_word[DATA_W + TAG_EOL] = last_col;
      wr_word[DATA_W + TAG_EOF] = last_col && last_row;
   end

   capture_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (wr_word),
      .full    (fifo_full),
      .rd_en   (pop),
      .rd_data (rd_word),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_cnt_q    <= '0;
         col_q        <= '0;
         row_q        <= '0;
         cam_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;

         // Position advances on every arrival so tags stay positional even when bytes drop
         if (cam_valid) begin
            if (last_col) begin
               col_q <= '0;
               row_q <= last_row ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end

         if (push && fifo_full && !pop) overflow_q <= 1'b1;

         case (state_q)
            IDLE: begin
               // The frame_done cycle is still IDLE; a start there is ignored
               if (start && !frame_done_q) begin
                  state_q    <= CAPTURE;
                  cam_en_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  req_cnt_q  <= '0;
                  col_q      <= '0;
                  row_q      <= '0;
                  overflow_q <= 1'b0;
               end
            end
            CAPTURE: begin
               if (req_cnt_q == RCW'(FTOTAL - 1)) begin
                  state_q  <= TAIL;
                  cam_en_q <= 1'b0;
               end else begin
                  req_cnt_q <= req_cnt_q + 1'b1;
               end
            end
            TAIL: state_q <= DRAIN;
            DRAIN: begin
               if (fifo_empty) begin
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cam_en     = cam_en_q;
   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;
   assign pix_valid  = !fifo_empty;
   assign pix_data   = fifo_empty ? '0 : rd_word[DATA_W-1:0];
   assign pix_sof    = !fifo_empty && rd_word[DATA_W + TAG_SOF];
   assign pix_eol    = !fifo_empty && rd_word[DATA_W + TAG_EOL];
   assign pix_eof    = !fifo_empty && rd_word[DATA_W + TAG_EOF];

endmodule

// File: tb/tb_camera_capture.sv
// tb/tb_camera_capture.sv - self-checking bench for camera_capture (DEPTH 16 and DEPTH 64 instances)
module tb_camera_capture;

   localparam int NPIX = 75;

   typedef struct {
      int dut;
      int md;
      int exp_del;
      int exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]      start_v = '0;
   logic [1:0]      ready_v = '0;
   logic [1:0]      cam_en_w, cam_valid_w, pix_valid_w, pix_sof_w, pix_eol_w, pix_eof_w;
   logic [1:0]      busy_w, overflow_w, frame_done_w;
   logic [1:0][7:0] cam_data_w, pix_data_w;

   logic [7:0]  rom [NPIX];
   int          depth [2] = '{16, 64};
   int          mode [2] = '{0, 0};
   bit          accept [2] = '{0, 0};
   bit          mon_en = 0;

   // behavioural model state
   logic [10:0] mq [2][128];
   int          hd [2], cnt [2], arr_idx [2], acc_cnt [2];
   bit          active [2], ovf_m [2];
   int          en_cnt [2], en_runs [2], done_cnt [2], deliv_cnt [2];
   bit          prev_en [2];
   logic [10:0] deliv [2][NPIX];
   int          cam_idx [2];

   int n_chk = 0;
   int n_fail = 0;

   camera_capture #(.DATA_W(8), .IMG_W(15), .IMG_H(5), .FIFO_DEPTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start_v[0]), .cam_en(cam_en_w[0]),
      .cam_valid(cam_valid_w[0]), .cam_data(cam_data_w[0]), .pix_valid(pix_valid_w[0]),
      .pix_ready(ready_v[0]), .pix_data(pix_data_w[0]), .pix_sof(pix_sof_w[0]),
      .pix_eol(pix_eol_w[0]), .pix_eof(pix_eof_w[0]), .busy(busy_w[0]),
      .overflow(overflow_w[0]), .frame_done(frame_done_w[0]));

   camera_capture #(.DATA_W(8), .IMG_W(15), .IMG_H(5), .FIFO_DEPTH(64)) u_dut64 (
      .clk(clk), .rst(rst), .start(start_v[1]), .cam_en(cam_en_w[1]),
      .cam_valid(cam_valid_w[1]), .cam_data(cam_data_w[1]), .pix_valid(pix_valid_w[1]),
      .pix_ready(ready_v[1]), .pix_data(pix_data_w[1]), .pix_sof(pix_sof_w[1]),
      .pix_eol(pix_eol_w[1]), .pix_eof(pix_eof_w[1]), .busy(busy_w[1]),
      .overflow(overflow_w[1]), .frame_done(frame_done_w[1]));

   // Camera: one-cycle registered response to cam_en, restarts whenever cam_en drops
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!cam_en_w[g]) begin
            cam_idx[g]     <= 0;
            cam_valid_w[g] <= 1'b0;
            cam_data_w[g]  <= 8'h00;
         end else begin
            cam_valid_w[g] <= 1'b1;
            cam_data_w[g]  <= rom[cam_idx[g] % NPIX];
            cam_idx[g]     <= cam_idx[g] + 1;
         end
      end
   end

   function automatic logic [10:0] mk(input int i);
      int  col;
      int  row;
      bit  eol;
      col = i % 15;
      row = i / 15;
      eol = (col == 14);
      return {(i == 0), eol, (eol && row == 4), rom[i]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Consumer ready policy, updated just after each clock edge
   initial forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         case (mode[d])
            1:       ready_v[d] = (arr_idx[d] >= NPIX);
            2:       ready_v[d] = !ready_v[d];
            3:       ready_v[d] = 1'($urandom_range(0, 1));
            4:       ready_v[d] = (arr_idx[d] >= 16);
            default: ready_v[d] = 1'b1;
         endcase
      end
   end

   // Reference model: a bounded queue fed by frame arrivals, compared every cycle
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            bit          pop;
            logic [10:0] head;
            head = {pix_sof_w[d], pix_eol_w[d], pix_eof_w[d], pix_data_w[d]};
            chk("pix_valid", 32'(pix_valid_w[d]), 32'(cnt[d] != 0));
            if (cnt[d] != 0) chk("pix_head", 32'(head), 32'(mq[d][hd[d]]));
            chk("overflow", 32'(overflow_w[d]), 32'(ovf_m[d]));
            en_cnt[d]   += int'(cam_en_w[d]);
            if (cam_en_w[d] && !prev_en[d]) en_runs[d]++;
            prev_en[d]  = cam_en_w[d];
            done_cnt[d] += int'(frame_done_w[d]);
            if (rst) begin
               cnt[d] = 0; hd[d] = 0; active[d] = 0; ovf_m[d] = 0;
            end else begin
               if (accept[d]) begin
                  ovf_m[d] = 0; arr_idx[d] = 0; active[d] = 1;
               end
               pop = (cnt[d] != 0) && ready_v[d];
               if (pop) begin
                  if (deliv_cnt[d] < NPIX) deliv[d][deliv_cnt[d]] = head;
                  deliv_cnt[d]++;
                  hd[d]  = (hd[d] + 1) % 128;
                  cnt[d]--;
               end
               if (cam_valid_w[d] && active[d] && arr_idx[d] < NPIX) begin
                  if (cnt[d] < depth[d]) begin
                     mq[d][(hd[d] + cnt[d]) % 128] = mk(arr_idx[d]);
                     cnt[d]++;
                     acc_cnt[d]++;
                  end else begin
                     ovf_m[d] = 1;
                  end
                  arr_idx[d]++;
               end
            end
         end
      end
   end

   task automatic launch(input int d, input int md);
      int w;
      w = 0;
      while (busy_w[d] && w < 3000) begin @(posedge clk); w++; end
      if (busy_w[d]) chk("idle_before_start_timeout", 32'(busy_w[d]), 32'd0);
      mode[d] = md;
      en_cnt[d] = 0; en_runs[d] = 0; done_cnt[d] = 0; deliv_cnt[d] = 0; acc_cnt[d] = 0;
      arr_idx[d] = 0;
      @(posedge clk); #2;
      start_v[d] = 1'b1; accept[d] = 1;
      @(posedge clk); #2;
      start_v[d] = 1'b0; accept[d] = 0;
   endtask

   task automatic run_frame(input int d, input int md, input int exp_del, input int exp_ovf,
                            input bit repulse);
      int w;
      launch(d, md);
      w = 0;
      while (done_cnt[d] == 0 && w < 3000) begin
         @(posedge clk); #2;
         w++;
         start_v[d] = repulse && (w == 10 || w == 40);
      end
      start_v[d] = 1'b0;
      if (done_cnt[d] == 0) chk("frame_done_timeout", 32'd0, 32'd1);
      repeat (5) @(posedge clk);
      #2;
      chk("cam_en_cycles", 32'(en_cnt[d]), 32'(NPIX));
      chk("cam_en_runs", 32'(en_runs[d]), 32'd1);
      chk("frame_done_pulses", 32'(done_cnt[d]), 32'd1);
      chk("delivered_vs_model", 32'(deliv_cnt[d]), 32'(acc_cnt[d]));
      if (exp_del >= 0) chk("delivered_count", 32'(deliv_cnt[d]), 32'(exp_del));
      if (exp_ovf >= 0) chk("overflow_final", 32'(overflow_w[d]), 32'(exp_ovf));
      chk("busy_after_frame", 32'(busy_w[d]), 32'd0);
      mode[d] = 0;
   endtask

   vec_t vecs [8];

   initial begin
      int w;
      for (int i = 0; i < NPIX; i++) rom[i] = 8'((i * 29 + 188) % 256);
      rom[14] = 8'h6E;
      rom[15] = 8'hBF;
      rom[74] = 8'hDE;
      for (int d = 0; d < 2; d++) begin
         hd[d] = 0; cnt[d] = 0; arr_idx[d] = 0; acc_cnt[d] = 0; active[d] = 0; ovf_m[d] = 0;
         en_cnt[d] = 0; en_runs[d] = 0; done_cnt[d] = 0; deliv_cnt[d] = 0; prev_en[d] = 0;
      end

      vecs[0] = '{dut: 0, md: 0, exp_del: 75, exp_ovf: 0};   // full frame, always ready
      vecs[1] = '{dut: 0, md: 1, exp_del: 16, exp_ovf: 1};   // stalled during capture
      vecs[2] = '{dut: 1, md: 2, exp_del: 75, exp_ovf: 0};   // DEPTH 64, toggling ready
      vecs[3] = '{dut: 0, md: 4, exp_del: 75, exp_ovf: 0};   // push+pop while full
      vecs[4] = '{dut: 1, md: 3, exp_del: -1, exp_ovf: -1};
      vecs[5] = '{dut: 0, md: 3, exp_del: -1, exp_ovf: -1};
      vecs[6] = '{dut: 0, md: 3, exp_del: -1, exp_ovf: -1};
      vecs[7] = '{dut: 1, md: 0, exp_del: 75, exp_ovf: 0};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_cam_en", 32'(cam_en_w[d]), 32'd0);
         chk("rst_pix_valid", 32'(pix_valid_w[d]), 32'd0);
         chk("rst_pix_word", 32'({pix_sof_w[d], pix_eol_w[d], pix_eof_w[d], pix_data_w[d]}), 32'd0);
         chk("rst_busy", 32'(busy_w[d]), 32'd0);
         chk("rst_overflow", 32'(overflow_w[d]), 32'd0);
         chk("rst_frame_done", 32'(frame_done_w[d]), 32'd0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      mon_en = 1;

      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].dut, vecs[i].md, vecs[i].exp_del, vecs[i].exp_ovf, 1'b0);
         if (i == 0) begin
            chk("first_pixel", 32'(deliv[0][0]), 32'h4BC);
            chk("pixel14", 32'(deliv[0][14]), 32'h26E);
            chk("pixel74", 32'(deliv[0][74]), 32'h3DE);
         end
         if (i == 1) begin
            chk("held_first", 32'(deliv[0][0]), 32'h4BC);
            chk("held_last", 32'(deliv[0][15][7:0]), 32'hBF);
         end
      end

      // start re-pulsed mid-capture is ignored
      run_frame(0, 0, 75, 0, 1'b1);

      // start on the frame_done cycle is ignored
      launch(0, 0);
      w = 0;
      while (w < 3000) begin
         @(posedge clk); #2;
         w++;
         if (frame_done_w[0]) break;
      end
      chk("done_seen", 32'(frame_done_w[0]), 32'd1);
      start_v[0] = 1'b1;
      @(posedge clk); #2;
      start_v[0] = 1'b0;
      @(negedge clk);
      chk("start_on_done_ignored", 32'(busy_w[0]), 32'd0);

      // reset in the middle of capture
      launch(0, 0);
      repeat (30) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_cam_en", 32'(cam_en_w[0]), 32'd0);
      chk("midrst_pix_valid", 32'(pix_valid_w[0]), 32'd0);
      chk("midrst_busy", 32'(busy_w[0]), 32'd0);
      repeat (5) @(posedge clk);
      chk("midrst_no_overflow", 32'(overflow_w[0]), 32'd0);
      run_frame(0, 0, 75, 0, 1'b0);
      chk("after_rst_first", 32'(deliv[0][0]), 32'h4BC);
      chk("after_rst_last", 32'(deliv[0][74]), 32'h3DE);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
